ram_fifo_ctrl: RTL and testbench
================================

# ram_fifo_ctrl

Synchronous FIFO controller that wraps a RAM with synchronous write and asynchronous read. It sits directly upstream of the RAM and drives its write and read ports, turning the bare array into a valid/ready streaming FIFO. It owns the read/write pointers, full/empty/count status and the handshakes on both sides. The RAM keeps the payload; this block holds no data except in the optional output register.

## Interface
Parameters:
- AWIDTH, 4: RAM address width; FIFO depth DEPTH = 2**AWIDTH.
- DWIDTH, 8: data width.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  producer has a word.
- s_ready  out  1  FIFO can accept a word.
- s_data  in  DWIDTH  producer word.
- m_valid  out  1  consumer word available.
- m_ready  in  1  consumer accepts the word.
- m_data  out  DWIDTH  consumer word.
- count  out  AWIDTH+2  number of words held, including the output register if present.
- full  out  1  no space; equals ~s_ready.
- empty  out  1  count == 0.
- ram_we  out  1  to RAM write enable.
- ram_waddr  out  AWIDTH  to RAM write address.
- ram_wdata  out  DWIDTH  to RAM write data.
- ram_re  out  1  to RAM read enable.
- ram_raddr  out  AWIDTH  to RAM read address.
- ram_rdata  in  DWIDTH  from RAM; asynchronous read of ram_raddr.

## Operation
- Pointers wr_ptr and rd_ptr are each AWIDTH+1 bits. The low AWIDTH bits address the RAM and the MSB is a wrap bit.
  - RAM is empty when wr_ptr == rd_ptr.
  - RAM is full when the low bits are equal and the MSBs differ.
- Push = s_valid & s_ready.
  - ram_we = push, ram_waddr = wr_ptr[AWIDTH-1:0], ram_wdata = s_data, all combinational.
  - wr_ptr increments on push and wraps naturally modulo 2**(AWIDTH+1).
- s_ready = ~(RAM full), with no exceptions. A pop in the same cycle does not open space for a push while full (no full pass-through).
- ram_raddr = rd_ptr[AWIDTH-1:0].
- ram_re = ~(RAM empty), so the RAM returns zero while empty.
- Pop = m_valid & m_ready. On a pop, rd_ptr increments (base build).
- Simultaneous push and pop when neither full nor empty: both pointers advance and count is unchanged.
- Push and pop on empty: only the push takes effect, because m_valid = 0 (no empty bypass).
- count is a registered counter with these updates per cycle:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on both or neither.
- Reset (any cycle, including mid-burst):
  - Pointers, count and the output register clear.
  - Outputs take these values: s_ready=1, full=0, empty=1, m_valid=0, m_data=0, count=0, ram_we=0, ram_re=0.
  - RAM contents are not cleared by this block, and stale words are never presented after reset.
- Illegal stimulus: s_valid while full is held off by the producer and has no effect. m_ready while m_valid=0 has no effect.

## Timing
- Base build (first-word fall-through):
  - m_valid = ~(RAM empty) and m_data = ram_rdata, combinational.
  - Write-to-read latency is 1 cycle: a word pushed at edge N is on m_data after edge N.
- The flags full and empty and the value count all reflect the state after the last edge. They have no combinational dependence on s_valid or m_ready.
- s_ready depends only on registered state. m_valid depends only on registered state.

## Configuration
- Macro: RAM_FIFO_CTRL_OUTREG_EN.
- Undefined: the base behaviour above applies. Capacity is DEPTH. m_data is combinational from the RAM.
- Defined: a one-entry output register (oreg, oreg_valid) drives m_valid and m_data directly, giving registered outputs.
  - oreg loads from ram_rdata, and rd_ptr increments, when RAM is non-empty and (oreg_valid=0 or pop).
  - Capacity becomes DEPTH+1; count and empty include oreg.
  - full still refers to the RAM alone.
  - Write-to-read latency is 2 cycles from empty.
  - Sustained throughput is one word per cycle.
  - Reset clears oreg to 0 and oreg_valid to 0.

## Test plan
All scenarios use AWIDTH=2, DWIDTH=8, DEPTH=4.
- Reset then idle -> s_ready=1, empty=1, m_valid=0, count=0, ram_we=0, ram_re=0 for 3 cycles.
- Push 0x11, 0x22, 0x33, 0x44 back to back with m_ready=0 -> full=1, s_ready=0, count=4, ram_waddr sequence 0,1,2,3. A 5th s_valid is ignored.
- Drain with m_ready=1 -> m_data 0x11, 0x22, 0x33, 0x44 on consecutive cycles, then empty=1 and m_valid=0. With OUTREG_EN: one extra cycle of latency and count peaks at 5 after a 5th push.
- Continuous push and pop for 10 words (0x00..0x09) -> pointers wrap past address 3, data order is preserved, count is steady at 1 (base build).
- Push while full with m_ready=1 -> push rejected that cycle, pop completes, count goes 4→3, s_ready=1 the next cycle.
- Assert rst mid-stream at count=3 -> all outputs return to their reset values the next cycle. A subsequent push of 0xA5 appears on m_data after 1 cycle (2 cycles with OUTREG_EN).

Source files
------------

// File: rtl/ram_fifo_ctrl.sv
// Valid/ready FIFO controller driving an external RAM (sync write, async read).
// Define RAM_FIFO_CTRL_OUTREG_EN to add a one-entry registered output stage.
module ram_fifo_ctrl #(
    parameter int AWIDTH = 4,
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DWIDTH-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DWIDTH-1:0] m_data,
    output logic [AWIDTH+1:0] count,
    output logic              full,
    output logic              empty,
    output logic              ram_we,
    output logic [AWIDTH-1:0] ram_waddr,
    output logic [DWIDTH-1:0] ram_wdata,
    output logic              ram_re,
    output logic [AWIDTH-1:0] ram_raddr,
    input  logic [DWIDTH-1:0] ram_rdata
);

    localparam logic [AWIDTH:0]   PTR_ONE = 1;
    localparam logic [AWIDTH+1:0] CNT_ONE = 1;

    logic [AWIDTH:0]   wr_ptr;
    logic [AWIDTH:0]   rd_ptr;
    logic [AWIDTH+1:0] count_q;
    logic              ram_empty;
    logic              ram_full;
    logic              push;
    logic              pop;
    logic              rd_adv;

    assign ram_empty = (wr_ptr == rd_ptr);
    assign ram_full  = (wr_ptr[AWIDTH-1:0] == rd_ptr[AWIDTH-1:0]) &&
                       (wr_ptr[AWIDTH] != rd_ptr[AWIDTH]);

    // No full pass-through: space only opens on the cycle after a pop.
    assign s_ready   = ~ram_full;
    assign full      = ram_full;
    assign push      = s_valid & s_ready;

    assign ram_we    = push;
    assign ram_waddr = wr_ptr[AWIDTH-1:0];
    assign ram_wdata = s_data;
    assign ram_re    = ~ram_empty;
    assign ram_raddr = rd_ptr[AWIDTH-1:0];

    assign count     = count_q;
    assign empty     = (count_q == '0);

`ifdef RAM_FIFO_CTRL_OUTREG_EN
    logic [DWIDTH-1:0] oreg;
    logic              oreg_valid;

    assign m_valid = oreg_valid;
    assign m_data  = oreg;
    assign pop     = oreg_valid & m_ready;
    // Refill the output stage whenever it is free or being drained this cycle.
    assign rd_adv  = ~ram_empty & (~oreg_valid | pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            oreg       <= '0;
            oreg_valid <= 1'b0;
        end else if (rd_adv) begin
            oreg       <= ram_rdata;
            oreg_valid <= 1'b1;
        end else if (pop) begin
            oreg_valid <= 1'b0;
        end
    end
`else
    assign m_valid = ~ram_empty;
    assign m_data  = ram_rdata;
    assign pop     = m_valid & m_ready;
    assign rd_adv  = pop;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_adv) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl with a behavioural RAM and a queue-based FIFO reference.
module tb_ram_fifo_ctrl;

    localparam int DEPTH = 4;
`ifdef RAM_FIFO_CTRL_OUTREG_EN
    localparam int CAP = DEPTH + 1;
    localparam int LAT = 2;
`else
    localparam int CAP = DEPTH;
    localparam int LAT = 1;
`endif

    logic       clk;
    logic       rst;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic       ram_we;
    logic [1:0] ram_waddr;
    logic [7:0] ram_wdata;
    logic       ram_re;
    logic [1:0] ram_raddr;
    logic [7:0] ram_rdata;

    int total = 0;
    int bad   = 0;

    ram_fifo_ctrl #(.AWIDTH(2), .DWIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .count(count), .full(full), .empty(empty),
        .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
        .ram_re(ram_re), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: synchronous write, asynchronous read returning zero when not enabled.
    logic [7:0] mem [DEPTH];
    initial for (int i = 0; i < DEPTH; i++) mem[i] = 8'hEE;
    always @(posedge clk) if (ram_we) mem[ram_waddr] <= ram_wdata;
    assign ram_rdata = ram_re ? mem[ram_raddr] : 8'h00;

    // Reference model: words held in the RAM, plus the optional output slot.
    logic [7:0]  ramq[$];
    logic [7:0]  oreg_m;
    bit          oreg_vm;
    int unsigned wcnt;
    int unsigned rcnt;

    function automatic bit exp_full();
        return ramq.size() == DEPTH;
    endfunction

    function automatic bit exp_mvalid();
`ifdef RAM_FIFO_CTRL_OUTREG_EN
        return oreg_vm;
`else
        return ramq.size() > 0;
`endif
    endfunction

    function automatic logic [7:0] exp_mdata();
`ifdef RAM_FIFO_CTRL_OUTREG_EN
        return oreg_m;
`else
        return (ramq.size() > 0) ? ramq[0] : 8'h00;
`endif
    endfunction

    function automatic logic [3:0] exp_count();
        return 4'(ramq.size() + (oreg_vm ? 1 : 0));
    endfunction

    task automatic model_reset();
        ramq.delete();
        oreg_m  = 8'h00;
        oreg_vm = 1'b0;
        wcnt    = 0;
        rcnt    = 0;
    endtask

    task automatic model_step(input bit sv, input logic [7:0] sd, input bit mr);
        bit pu;
        bit po;
        logic [7:0] tmp;
        pu = sv && (ramq.size() < DEPTH);
        po = exp_mvalid() && mr;
`ifdef RAM_FIFO_CTRL_OUTREG_EN
        if (ramq.size() > 0 && (!oreg_vm || po)) begin
            oreg_m  = ramq.pop_front();
            oreg_vm = 1'b1;
            rcnt++;
        end else if (po) begin
            oreg_vm = 1'b0;
        end
`else
        if (po) begin
            tmp = ramq.pop_front();
            rcnt++;
        end
`endif
        if (pu) begin
            ramq.push_back(sd);
            wcnt++;
        end
    endtask

    // Advance one clock: update the model with the inputs in force, return at the next negedge.
    task automatic tick();
        if (rst) model_reset();
        else     model_step(s_valid, s_data, m_ready);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0; s_data = 8'h00;
        #1;
        tick();
        tick();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL reset_s_ready got=%0b exp=1", s_ready); end
            total++; if (full !== 1'b0)    begin bad++; $display("FAIL reset_full got=%0b exp=0", full); end
            total++; if (empty !== 1'b1)   begin bad++; $display("FAIL reset_empty got=%0b exp=1", empty); end
            total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid got=%0b exp=0", m_valid); end
            total++; if (m_data !== 8'h00) begin bad++; $display("FAIL reset_m_data got=%0h exp=0", m_data); end
            total++; if (count !== 4'd0)   begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
            total++; if (ram_we !== 1'b0)  begin bad++; $display("FAIL reset_ram_we got=%0b exp=0", ram_we); end
            total++; if (ram_re !== 1'b0)  begin bad++; $display("FAIL reset_ram_re got=%0b exp=0", ram_re); end
            tick();
        end
    endtask

    task automatic test_fill();
        logic [7:0] w [4];
        w = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1; s_data = w[i]; m_ready = 1'b0;
            #1;
            total++; if (ram_we !== 1'b1) begin bad++; $display("FAIL fill_ram_we i=%0d got=%0b exp=1", i, ram_we); end
            total++; if (ram_waddr !== 2'(i)) begin bad++; $display("FAIL fill_waddr i=%0d got=%0d exp=%0d", i, ram_waddr, i); end
            total++; if (ram_wdata !== w[i]) begin bad++; $display("FAIL fill_wdata i=%0d got=%0h exp=%0h", i, ram_wdata, w[i]); end
            tick();
        end
        s_data = 8'h55;
        #1;
        total++; if (full !== exp_full()) begin bad++; $display("FAIL fill_full got=%0b exp=%0b", full, exp_full()); end
        total++; if (s_ready !== !exp_full()) begin bad++; $display("FAIL fill_s_ready got=%0b exp=%0b", s_ready, !exp_full()); end
        total++; if (count !== 4'(DEPTH)) begin bad++; $display("FAIL fill_count4 got=%0d exp=%0d", count, DEPTH); end
        total++; if (ram_we !== !exp_full()) begin bad++; $display("FAIL fill_5th_we got=%0b exp=%0b", ram_we, !exp_full()); end
        tick();
        s_valid = 1'b0;
        #1;
        total++; if (count !== 4'(CAP)) begin bad++; $display("FAIL fill_peak_count got=%0d exp=%0d", count, CAP); end
    endtask

    task automatic test_drain();
        logic [7:0] w [5];
        int k;
        w = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        k = 0;
        s_valid = 1'b0; m_ready = 1'b1;
        for (int c = 0; c < 20 && k < CAP; c++) begin
            #1;
            total++; if (m_valid !== exp_mvalid()) begin bad++; $display("FAIL drain_m_valid c=%0d got=%0b exp=%0b", c, m_valid, exp_mvalid()); end
            if (exp_mvalid()) begin
                total++; if (m_data !== w[k]) begin bad++; $display("FAIL drain_data k=%0d got=%0h exp=%0h", k, m_data, w[k]); end
                k++;
            end
            tick();
        end
        #1;
        total++; if (k !== CAP) begin bad++; $display("FAIL drain_words got=%0d exp=%0d", k, CAP); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL drain_empty got=%0b exp=1", empty); end
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL drain_m_valid_end got=%0b exp=0", m_valid); end
        m_ready = 1'b0;
    endtask

    task automatic test_stream();
        int sent;
        int rx;
        sent = 0; rx = 0;
        m_ready = 1'b1;
        for (int c = 0; c < 40 && rx < 10; c++) begin
            s_valid = (sent < 10);
            s_data  = 8'(sent);
            #1;
            total++; if (s_ready !== !exp_full()) begin bad++; $display("FAIL stream_s_ready c=%0d got=%0b exp=%0b", c, s_ready, !exp_full()); end
            total++; if (count !== exp_count()) begin bad++; $display("FAIL stream_count c=%0d got=%0d exp=%0d", c, count, exp_count()); end
            if (s_valid && ram_we) begin
                total++; if (ram_waddr !== 2'(wcnt % DEPTH)) begin bad++; $display("FAIL stream_waddr c=%0d got=%0d exp=%0d", c, ram_waddr, wcnt % DEPTH); end
            end
`ifndef RAM_FIFO_CTRL_OUTREG_EN
            if (c >= 1 && c <= 10) begin
                total++; if (count !== 4'd1) begin bad++; $display("FAIL stream_steady c=%0d got=%0d exp=1", c, count); end
            end
`endif
            if (s_valid && s_ready) sent++;
            if (m_valid) begin
                total++; if (m_data !== 8'(rx)) begin bad++; $display("FAIL stream_order got=%0h exp=%0h", m_data, rx); end
                rx++;
            end
            tick();
        end
        s_valid = 1'b0; m_ready = 1'b0;
        total++; if (rx !== 10) begin bad++; $display("FAIL stream_words got=%0d exp=10", rx); end
    endtask

    task automatic test_full_pop();
        s_valid = 1'b1; m_ready = 1'b0;
        for (int c = 0; c < 10 && !exp_full(); c++) begin
            s_data = 8'($urandom);
            #1;
            tick();
        end
        s_data = 8'h77; m_ready = 1'b1;
        #1;
        total++; if (ram_we !== 1'b0)  begin bad++; $display("FAIL fullpop_we got=%0b exp=0", ram_we); end
        total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL fullpop_s_ready got=%0b exp=0", s_ready); end
        total++; if (count !== 4'(CAP)) begin bad++; $display("FAIL fullpop_count_before got=%0d exp=%0d", count, CAP); end
        total++; if (m_data !== exp_mdata()) begin bad++; $display("FAIL fullpop_data got=%0h exp=%0h", m_data, exp_mdata()); end
        tick();
        s_valid = 1'b0; m_ready = 1'b0;
        #1;
        total++; if (count !== 4'(CAP - 1)) begin bad++; $display("FAIL fullpop_count_after got=%0d exp=%0d", count, CAP - 1); end
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL fullpop_s_ready_after got=%0b exp=1", s_ready); end
        m_ready = 1'b1;
        for (int c = 0; c < 10 && exp_mvalid(); c++) begin
            #1;
            total++; if (m_data !== exp_mdata()) begin bad++; $display("FAIL fullpop_drain got=%0h exp=%0h", m_data, exp_mdata()); end
            tick();
        end
        m_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit found;
        int lat;
        s_valid = 1'b1; m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_data = 8'h60 + 8'(i);
            #1;
            tick();
        end
        #1;
        total++; if (count !== 4'd3) begin bad++; $display("FAIL mid_count3 got=%0d exp=3", count); end
        rst = 1'b1; s_data = 8'hEE;
        tick();
        rst = 1'b0; s_valid = 1'b0;
        #1;
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL mid_s_ready got=%0b exp=1", s_ready); end
        total++; if (full !== 1'b0)    begin bad++; $display("FAIL mid_full got=%0b exp=0", full); end
        total++; if (empty !== 1'b1)   begin bad++; $display("FAIL mid_empty got=%0b exp=1", empty); end
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL mid_m_valid got=%0b exp=0", m_valid); end
        total++; if (m_data !== 8'h00) begin bad++; $display("FAIL mid_m_data got=%0h exp=0", m_data); end
        total++; if (count !== 4'd0)   begin bad++; $display("FAIL mid_count got=%0d exp=0", count); end
        total++; if (ram_re !== 1'b0)  begin bad++; $display("FAIL mid_ram_re got=%0b exp=0", ram_re); end
        total++; if (ram_we !== 1'b0)  begin bad++; $display("FAIL mid_ram_we got=%0b exp=0", ram_we); end
        s_valid = 1'b1; s_data = 8'hA5;
        #1;
        tick();
        s_valid = 1'b0;
        found = 1'b0; lat = 0;
        for (int c = 1; c <= 6 && !found; c++) begin
            #1;
            if (m_valid) begin
                found = 1'b1;
                lat = c;
            end else begin
                tick();
            end
        end
        total++; if (lat !== LAT) begin bad++; $display("FAIL mid_latency got=%0d exp=%0d", lat, LAT); end
        total++; if (m_data !== 8'hA5) begin bad++; $display("FAIL mid_a5 got=%0h exp=a5", m_data); end
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst     = ($urandom_range(0, 99) == 0);
            s_valid = (c % 100 < 50) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            m_ready = (c % 100 < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            s_data  = 8'($urandom);
            #1;
            total++; if (s_ready !== !exp_full()) begin bad++; $display("FAIL rand_s_ready c=%0d got=%0b exp=%0b", c, s_ready, !exp_full()); end
            total++; if (full !== exp_full()) begin bad++; $display("FAIL rand_full c=%0d got=%0b exp=%0b", c, full, exp_full()); end
            total++; if (count !== exp_count()) begin bad++; $display("FAIL rand_count c=%0d got=%0d exp=%0d", c, count, exp_count()); end
            total++; if (empty !== (exp_count() == 0)) begin bad++; $display("FAIL rand_empty c=%0d got=%0b exp=%0b", c, empty, exp_count() == 0); end
            total++; if (m_valid !== exp_mvalid()) begin bad++; $display("FAIL rand_m_valid c=%0d got=%0b exp=%0b", c, m_valid, exp_mvalid()); end
            total++; if (m_data !== exp_mdata()) begin bad++; $display("FAIL rand_m_data c=%0d got=%0h exp=%0h", c, m_data, exp_mdata()); end
            total++; if (ram_we !== (s_valid && !exp_full())) begin bad++; $display("FAIL rand_ram_we c=%0d got=%0b exp=%0b", c, ram_we, s_valid && !exp_full()); end
            total++; if (ram_re !== (ramq.size() > 0)) begin bad++; $display("FAIL rand_ram_re c=%0d got=%0b exp=%0b", c, ram_re, ramq.size() > 0); end
            total++; if (ram_waddr !== 2'(wcnt % DEPTH)) begin bad++; $display("FAIL rand_waddr c=%0d got=%0d exp=%0d", c, ram_waddr, wcnt % DEPTH); end
            total++; if (ram_raddr !== 2'(rcnt % DEPTH)) begin bad++; $display("FAIL rand_raddr c=%0d got=%0d exp=%0d", c, ram_raddr, rcnt % DEPTH); end
            total++; if (ram_wdata !== s_data) begin bad++; $display("FAIL rand_wdata c=%0d got=%0h exp=%0h", c, ram_wdata, s_data); end
            tick();
        end
        rst = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_fill();
        test_drain();
        test_stream();
        test_full_pop();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
